// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int REG_X0     = 0;
    localparam int NUM_WB_SRC = 3;

    // Requester slot assignment on the writeback request vector.
    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MDU = 2;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr) + off) % NUM_REQ;
            if (!grant_valid && req[IDX_W'(idx)]) begin
                grant_valid          = 1'b1;
                grant[IDX_W'(idx)]   = 1'b1;
                grant_idx            = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback port scheduler: round-robin grant, one registered write stage,
// and a per-register busy scoreboard for decode RAW checks.
module regfile_wb_scheduler #(
    parameter int NUM_REQ = regfile_wb_scheduler_pkg::NUM_WB_SRC,
    parameter int ADDR_W  = regfile_wb_scheduler_pkg::ADDR_W,
    parameter int DATA_W  = regfile_wb_scheduler_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      alloc_valid,
    input  logic [ADDR_W-1:0]         alloc_rd,
    input  logic [ADDR_W-1:0]         rs1,
    input  logic [ADDR_W-1:0]         rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         rd,
    output logic [DATA_W-1:0]         WriteData
);

    import regfile_wb_scheduler_pkg::*;

    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_REGS = 1 << ADDR_W;

    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_valid;
    logic [ADDR_W-1:0]   sel_rd;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] busy;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr),
        .grant       (req_ready),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Select the granted requester's destination and data.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_rd   = req_rd[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin pointer advances past the accepted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Registered write stage; x0 writes are consumed without enabling the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            rd        <= '0;
            WriteData <= '0;
        end else if (grant_valid) begin
            RegWrite  <= (sel_rd != ADDR_W'(REG_X0));
            rd        <= sel_rd;
            WriteData <= sel_data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    // Busy scoreboard: allocation sets, completed write clears, set wins on a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (alloc_valid && alloc_rd == ADDR_W'(r)) begin
                    busy[r] <= 1'b1;
                end else if (RegWrite && rd == ADDR_W'(r)) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: vector table plus scoreboard/reset sequences.
module tb_regfile_wb_scheduler;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_rd;
    logic [N*DW-1:0] req_data;
    logic            alloc_valid;
    logic [AW-1:0]   alloc_rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            RegWrite;
    logic [AW-1:0]   rd;
    logic [DW-1:0]   WriteData;

    int checks   = 0;
    int failures = 0;

    regfile_wb_scheduler #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .RegWrite    (RegWrite),
        .rd          (rd),
        .WriteData   (WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*AW-1:0] rdv;
        logic [N*DW-1:0] data;
        logic [N-1:0]    exp_ready;
        logic            exp_we;
        logic [AW-1:0]   exp_rd;
        logic [DW-1:0]   exp_wd;
        logic            chk_rdwd;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build a vector; each requester's data defaults to 0x100 + its rd.
    function automatic vec_t mkv(input logic [N-1:0] v, input int r2, input int r1, input int r0,
                                 input logic [N-1:0] er, input logic ewe, input int erd,
                                 input int ewd, input logic chk_rdwd);
        vec_t t;
        t.valid     = v;
        t.rdv       = {AW'(r2), AW'(r1), AW'(r0)};
        t.data      = {32'(r2) + 32'h100, 32'(r1) + 32'h100, 32'(r0) + 32'h100};
        t.exp_ready = er;
        t.exp_we    = ewe;
        t.exp_rd    = AW'(erd);
        t.exp_wd    = 32'(ewd);
        t.chk_rdwd  = chk_rdwd;
        return t;
    endfunction

    task automatic drive(input logic [N-1:0] v, input int r2, input int r1, input int r0);
        req_valid = v;
        req_rd    = {AW'(r2), AW'(r1), AW'(r0)};
        req_data  = {32'(r2) + 32'h100, 32'(r1) + 32'h100, 32'(r0) + 32'h100};
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
        alloc_valid = 1'b0; alloc_rd = '0; rs1 = 5'd7; rs2 = 5'd9;

        vecs[0]  = mkv(3'b010,  0,  5,  0, 3'b010, 1'b1,  5, 32'hDEADBEEF, 1'b1);
        vecs[0].data[63:32] = 32'hDEADBEEF;
        vecs[1]  = mkv(3'b100,  3,  0,  0, 3'b100, 1'b1,  3, 32'h103, 1'b1);
        vecs[2]  = mkv(3'b111, 12, 11, 10, 3'b001, 1'b1, 10, 32'h10A, 1'b1);
        vecs[3]  = mkv(3'b111, 12, 11, 13, 3'b010, 1'b1, 11, 32'h10B, 1'b1);
        vecs[4]  = mkv(3'b111, 12, 14, 13, 3'b100, 1'b1, 12, 32'h10C, 1'b1);
        vecs[5]  = mkv(3'b111, 15, 14, 13, 3'b001, 1'b1, 13, 32'h10D, 1'b1);
        vecs[6]  = mkv(3'b111, 15, 14, 16, 3'b010, 1'b1, 14, 32'h10E, 1'b1);
        vecs[7]  = mkv(3'b111, 15, 17, 16, 3'b100, 1'b1, 15, 32'h10F, 1'b1);
        vecs[8]  = mkv(3'b000,  0,  0,  0, 3'b000, 1'b0, 15, 32'h10F, 1'b1);
        vecs[9]  = mkv(3'b001,  0,  0,  0, 3'b001, 1'b0,  0, 0, 1'b0);
        vecs[9].data[31:0] = 32'h1;
        vecs[10] = mkv(3'b011,  0, 21, 20, 3'b010, 1'b1, 21, 32'h115, 1'b1);
        vecs[11] = mkv(3'b001,  0,  0, 20, 3'b001, 1'b1, 20, 32'h114, 1'b1);

        // Reset then idle
        tick(); tick();
        chk("rst_we",    64'(RegWrite),  64'd0);
        chk("rst_rd",    64'(rd),        64'd0);
        chk("rst_wd",    64'(WriteData), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_busy1", 64'(rs1_busy),  64'd0);
        chk("rst_busy2", 64'(rs2_busy),  64'd0);
        rst = 1'b0;
        tick();
        chk("idle_we",    64'(RegWrite),  64'd0);
        chk("idle_ready", 64'(req_ready), 64'd0);

        // Table: grant checked before the edge, write stage after it
        for (int i = 0; i < 12; i++) begin
            req_valid = vecs[i].valid;
            req_rd    = vecs[i].rdv;
            req_data  = vecs[i].data;
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
            tick();
            chk($sformatf("v%0d_we", i), 64'(RegWrite), 64'(vecs[i].exp_we));
            if (vecs[i].chk_rdwd) begin
                chk($sformatf("v%0d_rd", i), 64'(rd),        64'(vecs[i].exp_rd));
                chk($sformatf("v%0d_wd", i), 64'(WriteData), 64'(vecs[i].exp_wd));
            end
        end
        drive(3'b000, 0, 0, 0);

        // Scoreboard: allocate r7, write it back, observe clear one cycle late
        rs1 = 5'd7; rs2 = 5'd7;
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        #1;
        chk("sb_pre_alloc", 64'(rs1_busy), 64'd0);
        tick();
        alloc_valid = 1'b0;
        chk("sb_alloc_busy1", 64'(rs1_busy), 64'd1);
        chk("sb_alloc_busy2", 64'(rs2_busy), 64'd1);
        drive(3'b001, 0, 0, 7);
        #1;
        chk("sb_wr_ready", 64'(req_ready), 64'b001);
        tick();
        drive(3'b000, 0, 0, 0);
        chk("sb_wr_we",   64'(RegWrite), 64'd1);
        chk("sb_wr_rd",   64'(rd),       64'd7);
        chk("sb_wr_busy", 64'(rs1_busy), 64'd1);
        tick();
        chk("sb_clr_we",   64'(RegWrite), 64'd0);
        chk("sb_clr_busy", 64'(rs1_busy), 64'd0);

        // Allocate r7 while its write retires: set wins
        drive(3'b010, 0, 7, 0);
        #1;
        chk("sb_tie_ready", 64'(req_ready), 64'b010);
        tick();
        drive(3'b000, 0, 0, 0);
        chk("sb_tie_we", 64'(RegWrite), 64'd1);
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        tick();
        alloc_valid = 1'b0;
        chk("sb_tie_busy",  64'(rs1_busy), 64'd1);
        tick();
        chk("sb_tie_hold",  64'(rs1_busy), 64'd1);

        // x0 is never busy
        rs1 = 5'd0;
        alloc_valid = 1'b1; alloc_rd = 5'd0;
        tick();
        alloc_valid = 1'b0;
        chk("x0_busy", 64'(rs1_busy), 64'd0);

        // Reset with an accept and an allocation in the same cycle (ptr is 2 here)
        rst = 1'b1;
        drive(3'b001, 0, 0, 9);
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        tick();
        rst = 1'b0;
        alloc_valid = 1'b0;
        drive(3'b000, 0, 0, 0);
        rs1 = 5'd9; rs2 = 5'd7;
        chk("mrst_we",    64'(RegWrite),  64'd0);
        chk("mrst_rd",    64'(rd),        64'd0);
        chk("mrst_wd",    64'(WriteData), 64'd0);
        chk("mrst_busy9", 64'(rs1_busy),  64'd0);
        chk("mrst_busy7", 64'(rs2_busy),  64'd0);
        drive(3'b101, 2, 0, 1);
        #1;
        chk("mrst_ptr0", 64'(req_ready), 64'b001);
        tick();
        drive(3'b000, 0, 0, 0);
        chk("mrst_we2", 64'(RegWrite), 64'd1);
        chk("mrst_rd2", 64'(rd),       64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
